// File: rtl/series_req_master_pkg.sv
// Shared types and constants for the series-calculator request master.
package series_req_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_OUTPUT  = 2'd3
  } state_e;

  // Result fill on watchdog abort; sliced down to the result width by users.
  localparam logic [63:0] ERR_FILL_WIDE = '1;

endpackage

// File: rtl/series_req_master_if.sv
// Operand stream, core start/done handshake and result stream of the request master.
interface series_req_master_if #(
  parameter int XW = 16,
  parameter int RW = 18,
  parameter int TW = 4
);
  logic          in_valid;
  logic          in_ready;
  logic [XW-1:0] in_x;
  logic          calc_start;
  logic [XW-1:0] calc_x;
  logic          calc_done;
  logic [RW-1:0] calc_r;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_r;
  logic [TW-1:0] out_tag;
  logic          out_err;
  logic          busy;

  modport master (
    input  in_valid, in_x, calc_done, calc_r, out_ready,
    output in_ready, calc_start, calc_x, out_valid, out_r, out_tag, out_err, busy
  );

  modport slave (
    output in_valid, in_x, calc_done, calc_r, out_ready,
    input  in_ready, calc_start, calc_x, out_valid, out_r, out_tag, out_err, busy
  );
endinterface

// File: rtl/series_req_watchdog.sv
// Cycle counter that flags expiry on the TIMEOUT-th enabled cycle after a clear.
module series_req_watchdog #(
  parameter int TIMEOUT = 64,
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expire_o = en_i && (cnt_q == CW'(TIMEOUT - 1));
endmodule

// File: rtl/series_req_master.sv
// Initiator of the four-phase start/done handshake to one series-calculator core,
// with operand input stream, tagged result output stream and a watchdog abort.
module series_req_master
  import series_req_master_pkg::*;
#(
  parameter int XW      = 16,
  parameter int RW      = 18,
  parameter int TW      = 4,
  parameter int TIMEOUT = 64
) (
  input logic clk,
  input logic rst,
  series_req_master_if.master bus
);
  state_e        state_q;
  logic          in_ready_q;
  logic          calc_start_q;
  logic          out_valid_q;
  logic          out_err_q;
  logic          busy_q;
  logic [XW-1:0] calc_x_q;
  logic [RW-1:0] out_r_q;
  logic [TW-1:0] out_tag_q;
  logic [TW-1:0] tag_cnt_q;
  logic          wd_expire;

  series_req_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    ((state_q == ST_IDLE) && bus.in_valid),
    .en_i     (state_q == ST_ISSUE),
    .expire_o (wd_expire)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      calc_start_q <= 1'b0;
      calc_x_q     <= '0;
      out_valid_q  <= 1'b0;
      out_r_q      <= '0;
      out_tag_q    <= '0;
      out_err_q    <= 1'b0;
      busy_q       <= 1'b0;
      tag_cnt_q    <= '0;
    end else begin
      case (state_q)
        ST_IDLE: if (bus.in_valid) begin
          calc_x_q     <= bus.in_x;
          out_tag_q    <= tag_cnt_q;
          tag_cnt_q    <= tag_cnt_q + TW'(1);
          calc_start_q <= 1'b1;
          in_ready_q   <= 1'b0;
          busy_q       <= 1'b1;
          state_q      <= ST_ISSUE;
        end
        // done has priority over a watchdog expiry in the same cycle
        ST_ISSUE: if (bus.calc_done) begin
          out_r_q      <= bus.calc_r;
          out_err_q    <= 1'b0;
          calc_start_q <= 1'b0;
          state_q      <= ST_RELEASE;
        end else if (wd_expire) begin
          out_r_q      <= ERR_FILL_WIDE[RW-1:0];
          out_err_q    <= 1'b1;
          calc_start_q <= 1'b0;
          state_q      <= ST_RELEASE;
        end
        // wait for the core to drop done before anything new can start
        ST_RELEASE: if (!bus.calc_done) begin
          out_valid_q <= 1'b1;
          state_q     <= ST_OUTPUT;
        end
        ST_OUTPUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.calc_start = calc_start_q;
  assign bus.calc_x     = calc_x_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_r      = out_r_q;
  assign bus.out_tag    = out_tag_q;
  assign bus.out_err    = out_err_q;
  assign bus.busy       = busy_q;
endmodule

// File: tb/tb_series_req_master.sv
// Bench for series_req_master: behavioural core model plus per-job expectations
// derived from core latency, done hold time and the watchdog limit.
module tb_series_req_master;
  localparam int XW = 16;
  localparam int RW = 18;
  localparam int TW = 4;
  localparam int TIMEOUT = 64;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic rst = 1'b1;

  series_req_master_if #(.XW(XW), .RW(RW), .TW(TW)) bus ();

  series_req_master #(.XW(XW), .RW(RW), .TW(TW), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Core model: done rises after core_lat observed start-high edges, drops
  // core_hold edges after start is seen low. core_lat==0 means never done.
  int            core_lat = 0;
  int            core_hold = 0;
  logic [RW-1:0] core_r = '0;
  int            c_cnt;
  int            c_hold;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      c_cnt <= 0;
      c_hold <= 0;
      bus.calc_done <= 1'b0;
      bus.calc_r <= '0;
    end else if (bus.calc_start) begin
      c_cnt <= c_cnt + 1;
      c_hold <= core_hold;
      if (core_lat != 0 && c_cnt == core_lat - 1) begin
        bus.calc_done <= 1'b1;
        bus.calc_r <= core_r;
      end
    end else begin
      c_cnt <= 0;
      if (bus.calc_done) begin
        if (c_hold == 0) bus.calc_done <= 1'b0;
        else c_hold <= c_hold - 1;
      end
    end
  end

  // Shortest run of start-low cycles between two start pulses.
  int  low_run = 0;
  int  min_gap = 1000;
  bit  seen_start = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      low_run <= 0;
      seen_start <= 1'b0;
    end else if (bus.calc_start) begin
      if (seen_start && low_run > 0 && low_run < min_gap) min_gap <= low_run;
      seen_start <= 1'b1;
      low_run <= 0;
    end else begin
      low_run <= low_run + 1;
    end
  end

  int exp_tag = 0;

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_tag = 0;
  endtask

  task automatic do_job(input logic [XW-1:0] x, input int lat, input int hold,
                        input logic [RW-1:0] r, input int bp, input bit keep,
                        input logic [XW-1:0] next_x);
    int n, st, k, xerr, serr, ferr;
    bit done_ok;
    int exp_len, exp_k;
    logic [RW-1:0] exp_r;
    logic [TW-1:0] exp_t;
    done_ok = (lat >= 1) && (lat <= TIMEOUT - 1);
    exp_len = done_ok ? lat + 1 : TIMEOUT;
    exp_k   = done_ok ? 2 + hold : 1;
    exp_r   = done_ok ? r : {RW{1'b1}};
    exp_t   = exp_tag[TW-1:0];
    core_lat = lat;
    core_hold = hold;
    core_r = r;
    bus.in_valid = 1'b1;
    bus.in_x = x;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(n >= LIMIT), 0);
    @(negedge clk);
    exp_tag = (exp_tag + 1) % (1 << TW);
    bus.in_valid = keep;
    bus.in_x = keep ? next_x : XW'($urandom);
    chk("start_after_accept", bus.calc_start, 1);
    chk("in_ready_busy", bus.in_ready, 0);
    chk("busy", bus.busy, 1);
    st = 0;
    xerr = 0;
    while (bus.calc_start && st < LIMIT) begin
      if (bus.calc_x !== x) xerr++;
      st++;
      @(negedge clk);
    end
    chk("start_len", st, exp_len);
    chk("calc_x_hold", xerr, 0);
    k = 0;
    serr = 0;
    while (!bus.out_valid && k < LIMIT) begin
      if (bus.calc_start || !bus.busy || bus.in_ready) serr++;
      @(negedge clk);
      k++;
    end
    chk("valid_latency", k, exp_k);
    chk("release_quiet", serr, 0);
    chk("out_r", bus.out_r, exp_r);
    chk("out_tag", bus.out_tag, exp_t);
    chk("out_err", bus.out_err, !done_ok);
    ferr = 0;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      if (!bus.out_valid || bus.out_r !== exp_r || bus.out_tag !== exp_t ||
          bus.out_err !== !done_ok || bus.calc_start || bus.in_ready) ferr++;
    end
    chk("hold_stable", ferr, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("valid_drop", bus.out_valid, 0);
    chk("idle_ready", bus.in_ready, 1);
    chk("idle_busy", bus.busy, 0);
  endtask

  logic [XW-1:0] ops [0:17];
  int lat;
  int n;

  initial begin
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_calc_start", bus.calc_start, 0);
    chk("rst_calc_x", bus.calc_x, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_r", bus.out_r, 0);
    chk("rst_out_tag", bus.out_tag, 0);
    chk("rst_out_err", bus.out_err, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    do_job(16'h4000, 26, 0, 18'h03920, 0, 1'b0, '0);

    do_reset();
    for (int i = 0; i < 18; i++) ops[i] = XW'($urandom);
    min_gap = 1000;
    for (int i = 0; i < 17; i++)
      do_job(ops[i], $urandom_range(1, 20), $urandom_range(0, 2), RW'($urandom), 0,
             i < 16, ops[i+1]);
    chk("start_gap_ge2", 64'(min_gap >= 2), 1);

    do_job(XW'($urandom), 0, 0, RW'($urandom), 1, 1'b0, '0);
    do_job(XW'($urandom), 63, 0, 18'h00123, 0, 1'b0, '0);
    do_job(XW'($urandom), 10, 5, RW'($urandom), 10, 1'b0, '0);

    for (int i = 0; i < 6; i++) begin
      lat = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 63);
      do_job(XW'($urandom), lat, $urandom_range(0, 3), RW'($urandom),
             $urandom_range(0, 3), 1'b0, '0);
    end

    core_lat = 0;
    bus.in_valid = 1'b1;
    bus.in_x = XW'($urandom);
    n = 0;
    while (!bus.in_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_rst_start", bus.calc_start, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_start", bus.calc_start, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_ready", bus.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    exp_tag = 0;
    do_job(XW'($urandom), 5, 0, RW'($urandom), 0, 1'b0, '0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/series_req_master.md
Name: series_req_master

Overview:
- Initiator side of the series-calculator start/done handshake.
- Accepts operands from an upstream valid/ready stream.
- Drives a four-phase start/done handshake into one series-calculator core (ln(x+1) or exp), captures the core result, and returns it downstream on a valid/ready stream with a sequence tag and an error flag.
- A watchdog aborts a job if the core never raises done.

Parameters:
XW, 16, operand width (calc_x, in_x)
RW, 18, result width (calc_r, out_r)
TW, 4, sequence tag width; tag wraps modulo 2^TW
TIMEOUT, 64, max cycles start may stay high without done; must be >= 2

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  upstream operand valid
in_ready  output  1  block can accept operand
in_x  input  XW  operand
calc_start  output  1  start request to core
calc_x  output  XW  operand to core, registered, stable while job active
calc_done  input  1  core done, level
calc_r  input  RW  core result, valid while calc_done=1
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_r  output  RW  captured result
out_tag  output  TW  sequence number of the job
out_err  output  1  1 = job aborted by watchdog
busy  output  1  state != IDLE

Behaviour:
- Reset values:
  - All outputs 0 except in_ready=1.
  - state=IDLE, tag counter=0, watchdog=0, calc_x=0.
  - A reset mid-job returns to IDLE immediately and drops calc_start.
- States: IDLE, ISSUE, RELEASE, OUTPUT.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_x into calc_x, latch the tag counter into out_tag, increment the tag counter (wrap 2^TW-1→0), clear the watchdog, and go to ISSUE.
  - calc_start stays low in IDLE.
- ISSUE:
  - calc_start=1 (registered; first high cycle is the cycle after acceptance).
  - calc_x is held; the watchdog increments every cycle.
  - If calc_done=1: capture calc_r into out_r, set out_err=0, go to RELEASE.
  - Else if watchdog==TIMEOUT-1: set out_r={RW{1}}, set out_err=1, go to RELEASE.
  - If done and timeout occur in the same cycle, done wins.
- RELEASE:
  - calc_start=0.
  - Stay until calc_done=0 is sampled, then go to OUTPUT.
  - This guarantees the core has returned to idle before any new start. There is no timeout here.
- OUTPUT:
  - out_valid=1; out_r, out_tag and out_err are held stable.
  - On out_ready, go to IDLE.
  - out_valid deasserts in the following cycle.
- in_ready=0 in every state except IDLE; in_x is ignored there.
- calc_start is never high in two consecutive jobs without at least one low cycle in between. RELEASE and OUTPUT together give at least 2 low cycles.
- A calc_done that is high while in IDLE or OUTPUT (spurious) is ignored.
- Latency:
  - Acceptance edge → calc_start high: 1 cycle.
  - calc_done sampled → RELEASE: 1 cycle.
  - calc_done low sampled → out_valid: 1 cycle.
  - Total = core latency + 3 cycles, plus any core done-fall delay.
- Throughput: one job in flight, no operand buffering.
- Arithmetic: out_r is captured unmodified; no saturation or sign handling in this block.

Decomposition:
- Shared package: state enum (IDLE=0, ISSUE=1, RELEASE=2, OUTPUT=3, 2 bits) and the error-fill constant (all-ones result).
- One sub-module: series_req_watchdog.
  - Counter with clear/enable/expire; parameterized TIMEOUT; asynchronous reset.
  - Width = $clog2(TIMEOUT).

Test Plan:
- Normal job:
  - Stimulus: reset, then in_x=0x4000; core model raises done 26 cycles after start with calc_r=0x03920; out_ready=1.
  - Required: calc_start high 1 cycle after acceptance; calc_x=0x4000 throughout; out_r=0x03920, out_tag=0, out_err=0; out_valid 3 cycles after done rises.
- Back-to-back jobs:
  - Stimulus: 17 operands with in_valid held high.
  - Required: tags 0..15 then 0; in_ready low while busy; calc_start low for at least 2 cycles between jobs.
- Timeout:
  - Stimulus: core never raises done, TIMEOUT=64.
  - Required: calc_start high exactly 64 cycles; out_r=0x3FFFF, out_err=1; block returns to IDLE after out_ready.
- Done at the timeout cycle:
  - Stimulus: done rises in the same cycle the watchdog reaches 63, with calc_r=0x00123.
  - Required: out_r=0x00123, out_err=0.
- Backpressure and slow done-fall:
  - Stimulus: out_ready=0 for 10 cycles; core holds done for 5 cycles after start falls.
  - Required: block stays in RELEASE until done=0; out fields stable while out_valid=1; no new start issued.
- Reset mid-ISSUE:
  - Stimulus: assert rst at cycle 10 of a job.
  - Required: calc_start, out_valid and busy drop immediately; in_ready=1; tag counter=0.
